bn_dmux_sched: RTL and testbench

//  Two-phase scheduler for a 1-to-2 demux in the batch-normalization datapath.
//  Per batch, routes BATCH_LEN beats to consumer 0 (statistics pass), waits for stat_done,

---
 rtl/bn_dmux_sched.sv | 131 +++++++++++++
 tb/tb_bn_dmux_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_dmux_sched.sv
// Two-phase 1-to-2 demux scheduler for batch normalization: STAT beats to o0, wait for stat_done, NORM beats to o1.
// Optional BN_DMUX_STALL_CNT_EN adds a saturating stall_cnt output counting upstream back-pressure cycles.
module bn_dmux_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int BATCH_LEN  = 64,
  parameter int CNT_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stat_done,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  o0_valid,
  output logic [DATA_WIDTH-1:0] o0_data,
  input  logic                  o0_ready,
  output logic                  o1_valid,
  output logic [DATA_WIDTH-1:0] o1_data,
  input  logic                  o1_ready,
  output logic                  sel,
  output logic [1:0]            phase,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic                  busy,
  output logic                  done
`ifdef BN_DMUX_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STAT = 2'd1,
    WAIT = 2'd2,
    NORM = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_sel;
  logic             r_done;
  logic             w_fire;
  logic             w_last;
  logic             w_start_acc;
  logic             w_stat_acc;

  assign w_fire      = in_valid & in_ready;
  assign w_last      = (r_beat_cnt == CNT_W'(BATCH_LEN - 1));
  assign w_start_acc = (r_state == IDLE) & start;
  assign w_stat_acc  = (r_state == WAIT) & stat_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)           w_next = STAT;
      STAT:    if (w_fire && w_last) w_next = WAIT;
      WAIT:    if (stat_done)       w_next = NORM;
      NORM:    if (w_fire && w_last) w_next = IDLE;
      default:                      w_next = IDLE;
    endcase
  end

  // in_ready is masked during reset so no beat is consumed in the reset cycle.
  always_comb begin
    in_ready = 1'b0;
    o0_valid = 1'b0;
    o1_valid = 1'b0;
    case (r_state)
      STAT: begin
        o0_valid = in_valid;
        in_ready = o0_ready & ~rst;
      end
      NORM: begin
        o1_valid = in_valid;
        in_ready = o1_ready & ~rst;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
    o0_data  = r_sel ? '0 : in_data;
    o1_data  = r_sel ? in_data : '0;
    phase    = r_state;
    busy     = (r_state != IDLE);
    beat_cnt = r_beat_cnt;
    sel      = r_sel;
    done     = r_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_sel      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == NORM) & w_fire & w_last;
      if (w_start_acc || w_stat_acc)
        r_beat_cnt <= '0;
      else if (w_fire)
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + CNT_W'(1);
      // Phase entries never coincide with a fire, so sel cannot move under a live beat.
      if (w_start_acc)
        r_sel <= 1'b0;
      else if (w_stat_acc)
        r_sel <= 1'b1;
    end
  end

`ifdef BN_DMUX_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_start_acc)
      r_stall_cnt <= '0;
    else if ((r_state == STAT || r_state == NORM) && in_valid && !in_ready && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bn_dmux_sched.sv
// Bench for bn_dmux_sched: directed scenarios on a BATCH_LEN=4 instance, a BATCH_LEN=1 instance,
// and randomized traffic on both compared against a batch-progress reference model.
module tb_bn_dmux_sched;
  localparam int DW   = 16;
  localparam int BL_A = 4;
  localparam int CW_A = 3;
  localparam int BL_B = 1;
  localparam int CW_B = 1;

  logic          clk = 1'b0;
  logic          rst, start, stat_done, in_valid, o0_ready, o1_ready;
  logic [DW-1:0] in_data;

  logic            a_in_ready, a_o0_valid, a_o1_valid, a_sel, a_busy, a_done;
  logic [DW-1:0]   a_o0_data, a_o1_data;
  logic [1:0]      a_phase;
  logic [CW_A-1:0] a_beat_cnt;
  logic            b_in_ready, b_o0_valid, b_o1_valid, b_sel, b_busy, b_done;
  logic [DW-1:0]   b_o0_data, b_o1_data;
  logic [1:0]      b_phase;
  logic [CW_B-1:0] b_beat_cnt;
`ifdef BN_DMUX_STALL_CNT_EN
  logic [31:0]     a_stall_cnt, b_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bn_dmux_sched #(.DATA_WIDTH(DW), .BATCH_LEN(BL_A), .CNT_W(CW_A)) u_a (
    .clk(clk), .rst(rst), .start(start), .stat_done(stat_done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .o0_valid(a_o0_valid), .o0_data(a_o0_data), .o0_ready(o0_ready),
    .o1_valid(a_o1_valid), .o1_data(a_o1_data), .o1_ready(o1_ready),
    .sel(a_sel), .phase(a_phase), .beat_cnt(a_beat_cnt), .busy(a_busy), .done(a_done)
`ifdef BN_DMUX_STALL_CNT_EN
    , .stall_cnt(a_stall_cnt)
`endif
  );

  bn_dmux_sched #(.DATA_WIDTH(DW), .BATCH_LEN(BL_B), .CNT_W(CW_B)) u_b (
    .clk(clk), .rst(rst), .start(start), .stat_done(stat_done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .o0_valid(b_o0_valid), .o0_data(b_o0_data), .o0_ready(o0_ready),
    .o1_valid(b_o1_valid), .o1_data(b_o1_data), .o1_ready(o1_ready),
    .sel(b_sel), .phase(b_phase), .beat_cnt(b_beat_cnt), .busy(b_busy), .done(b_done)
`ifdef BN_DMUX_STALL_CNT_EN
    , .stall_cnt(b_stall_cnt)
`endif
  );

  // Reference model: a batch is 2*BL beats; phase is derived from how far the batch has progressed.
  int          bl[2];
  bit          m_active[2];
  int          m_beats[2];
  bit          m_statok[2];
  bit          m_sel[2];
  bit          m_done[2];
  logic [31:0] m_stall[2];

  function automatic int exp_phase(int k);
    if (!m_active[k])         return 0;
    if (m_beats[k] < bl[k])   return 1;
    if (!m_statok[k])         return 2;
    return 3;
  endfunction

  function automatic int exp_cnt(int k);
    case (exp_phase(k))
      1:       return m_beats[k];
      3:       return m_beats[k] - bl[k];
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_ready(int k);
    int ph;
    ph = exp_phase(k);
    return !rst && ((ph == 1 && o0_ready) || (ph == 3 && o1_ready));
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int ph;
      bit rdy;
      ph  = exp_phase(k);
      rdy = exp_ready(k);
      if (rst) begin
        m_active[k] = 0; m_beats[k] = 0; m_statok[k] = 0;
        m_sel[k] = 0; m_done[k] = 0; m_stall[k] = '0;
      end else begin
        m_done[k] = 0;
        if ((ph == 1 || ph == 3) && in_valid && !rdy && m_stall[k] != 32'hFFFF_FFFF)
          m_stall[k] = m_stall[k] + 32'd1;
        if (ph == 0 && start) begin
          m_active[k] = 1; m_beats[k] = 0; m_statok[k] = 0; m_sel[k] = 0; m_stall[k] = '0;
        end
        if (ph == 2 && stat_done) begin
          m_statok[k] = 1; m_sel[k] = 1;
        end
        if (in_valid && rdy) begin
          m_beats[k] = m_beats[k] + 1;
          if (m_beats[k] == 2 * bl[k]) begin
            m_active[k] = 0; m_done[k] = 1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stat_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1; in_data = 16'h1234;
    do_reset();
    #1;
    checks++; if (a_phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d exp 0", a_phase); end
    checks++; if (a_beat_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", a_beat_cnt); end
    checks++; if (a_sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b exp 0", a_sel); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", a_done); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", a_busy); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", a_in_ready); end
    checks++; if (a_o0_valid !== 1'b0) begin errors++; $display("FAIL reset_o0_valid: got %b exp 0", a_o0_valid); end
    checks++; if (b_phase !== 2'd0) begin errors++; $display("FAIL reset_b_phase: got %0d exp 0", b_phase); end
`ifdef BN_DMUX_STALL_CNT_EN
    checks++; if (a_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d exp 0", a_stall_cnt); end
`endif
  endtask

  task automatic test_basic();
    do_reset();
    in_valid = 1'b1; o0_ready = 1'b1; o1_ready = 1'b0; start = 1'b1; in_data = 16'h00ff;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL basic_idle_ready: got %b exp 0", a_in_ready); end
    tick();
    start = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      in_data = DW'(b);
      #1;
      checks++; if (a_phase !== 2'd1) begin errors++; $display("FAIL basic_stat_phase: got %0d exp 1", a_phase); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL basic_stat_ready: got %b exp 1", a_in_ready); end
      checks++; if (a_o0_valid !== 1'b1 || a_o1_valid !== 1'b0) begin errors++; $display("FAIL basic_stat_valid: got %b%b exp 10", a_o0_valid, a_o1_valid); end
      checks++; if (a_o0_data !== DW'(b)) begin errors++; $display("FAIL basic_o0_data: got %0d exp %0d", a_o0_data, b); end
      checks++; if (a_o1_data !== '0) begin errors++; $display("FAIL basic_o1_zero: got %0d exp 0", a_o1_data); end
      checks++; if (a_beat_cnt !== CW_A'(b - 1)) begin errors++; $display("FAIL basic_stat_cnt: got %0d exp %0d", a_beat_cnt, b - 1); end
      tick();
    end
    for (int w = 0; w < 3; w++) begin
      stat_done = (w == 2);
      in_data = 16'hdead;
      #1;
      checks++; if (a_phase !== 2'd2) begin errors++; $display("FAIL basic_wait_phase: got %0d exp 2", a_phase); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL basic_wait_ready: got %b exp 0", a_in_ready); end
      checks++; if (a_o0_valid !== 1'b0 || a_o1_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_valid: got %b%b exp 00", a_o0_valid, a_o1_valid); end
      tick();
    end
    stat_done = 1'b0; o1_ready = 1'b1;
    for (int b = 5; b <= 8; b++) begin
      in_data = DW'(b);
      #1;
      checks++; if (a_phase !== 2'd3 || a_sel !== 1'b1) begin errors++; $display("FAIL basic_norm_state: got phase %0d sel %b exp 3 1", a_phase, a_sel); end
      checks++; if (a_o1_valid !== 1'b1 || a_in_ready !== 1'b1) begin errors++; $display("FAIL basic_norm_hs: got v%b r%b exp 1 1", a_o1_valid, a_in_ready); end
      checks++; if (a_o1_data !== DW'(b)) begin errors++; $display("FAIL basic_o1_data: got %0d exp %0d", a_o1_data, b); end
      checks++; if (a_o0_data !== '0) begin errors++; $display("FAIL basic_o0_zero: got %0d exp 0", a_o0_data); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %b exp 0", a_done); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (a_done !== 1'b1 || a_phase !== 2'd0) begin errors++; $display("FAIL basic_done: got done %b phase %0d exp 1 0", a_done, a_phase); end
    tick();
    #1;
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b exp 0", a_done); end
  endtask

  task automatic test_stall();
    int delivered;
    delivered = 0;
    do_reset();
    in_valid = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      o0_ready = !(c >= 2 && c < 5);
      in_data = DW'(100 + c);
      #1;
      if (c >= 2 && c < 5) begin
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b exp 0", a_in_ready); end
        checks++; if (a_beat_cnt !== 3'd2) begin errors++; $display("FAIL stall_cnt_hold: got %0d exp 2", a_beat_cnt); end
      end
      if (a_in_ready === 1'b1) delivered++;
      tick();
    end
    #1;
    checks++; if (delivered !== 4) begin errors++; $display("FAIL stall_delivered: got %0d exp 4", delivered); end
    checks++; if (a_phase !== 2'd2) begin errors++; $display("FAIL stall_wait: got %0d exp 2", a_phase); end
`ifdef BN_DMUX_STALL_CNT_EN
    checks++; if (a_stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_count: got %0d exp 3", a_stall_cnt); end
    tick(); tick();
    #1;
    checks++; if (a_stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_count_wait: got %0d exp 3", a_stall_cnt); end
`endif
  endtask

  task automatic test_ignore();
    do_reset();
    in_valid = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      stat_done = (b == 1);
      tick();
    end
    stat_done = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1;
      checks++; if (a_phase !== 2'd2) begin errors++; $display("FAIL ignore_wait_%0d: got %0d exp 2", w, a_phase); end
      tick();
    end
    stat_done = 1'b1;
    tick();
    stat_done = 1'b0;
    for (int b = 0; b < 4; b++) begin
      start = (b == 1);
      #1;
      checks++; if (a_phase !== 2'd3 || a_beat_cnt !== CW_A'(b)) begin errors++; $display("FAIL ignore_norm: got phase %0d cnt %0d exp 3 %0d", a_phase, a_beat_cnt, b); end
      tick();
    end
    start = 1'b0;
    #1;
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b exp 1", a_done); end
    tick(); tick();
    #1;
    checks++; if (a_phase !== 2'd0 || a_busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got phase %0d busy %b exp 0 0", a_phase, a_busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 4; b++) tick();
    stat_done = 1'b1;
    tick();
    stat_done = 1'b0;
    tick(); tick();
    #1;
    checks++; if (a_phase !== 2'd3 || a_beat_cnt !== 3'd2) begin errors++; $display("FAIL rstmid_pre: got phase %0d cnt %0d exp 3 2", a_phase, a_beat_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_rst_cycle_ready: got %b exp 0", a_in_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (a_phase !== 2'd0 || a_sel !== 1'b0) begin errors++; $display("FAIL rstmid_state: got phase %0d sel %b exp 0 0", a_phase, a_sel); end
    checks++; if (a_beat_cnt !== 3'd0 || a_done !== 1'b0) begin errors++; $display("FAIL rstmid_cnt_done: got cnt %0d done %b exp 0 0", a_beat_cnt, a_done); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b exp 0", a_in_ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 4; b++) tick();
    stat_done = 1'b1;
    tick();
    stat_done = 1'b0;
    for (int b = 0; b < 4; b++) tick();
    start = 1'b1;
    #1;
    checks++; if (a_done !== 1'b1 || a_phase !== 2'd0) begin errors++; $display("FAIL b2b_done_cycle: got done %b phase %0d exp 1 0", a_done, a_phase); end
    checks++; if (a_sel !== 1'b1) begin errors++; $display("FAIL b2b_sel_hold: got %b exp 1", a_sel); end
    tick();
    start = 1'b0;
    #1;
    checks++; if (a_phase !== 2'd1 || a_sel !== 1'b0) begin errors++; $display("FAIL b2b_restart: got phase %0d sel %b exp 1 0", a_phase, a_sel); end
    checks++; if (a_beat_cnt !== 3'd0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_cnt_ready: got cnt %0d rdy %b exp 0 1", a_beat_cnt, a_in_ready); end
  endtask

  task automatic test_len1();
    int fires;
    fires = 0;
    do_reset();
    in_valid = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    checks++; if (b_phase !== 2'd1) begin errors++; $display("FAIL len1_stat: got %0d exp 1", b_phase); end
    if (b_in_ready === 1'b1) fires++;
    tick();
    #1;
    checks++; if (b_phase !== 2'd2) begin errors++; $display("FAIL len1_wait: got %0d exp 2", b_phase); end
    stat_done = 1'b1;
    tick();
    stat_done = 1'b0;
    #1;
    checks++; if (b_phase !== 2'd3 || b_sel !== 1'b1) begin errors++; $display("FAIL len1_norm: got phase %0d sel %b exp 3 1", b_phase, b_sel); end
    if (b_in_ready === 1'b1) fires++;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (b_done !== 1'b1 || b_phase !== 2'd0) begin errors++; $display("FAIL len1_done: got done %b phase %0d exp 1 0", b_done, b_phase); end
    checks++; if (fires !== 2) begin errors++; $display("FAIL len1_fires: got %0d exp 2", fires); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stat_done = ($urandom_range(0, 3) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      o0_ready  = ($urandom_range(0, 3) != 0);
      o1_ready  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        logic [1:0]    ap;
        logic [7:0]    ac;
        logic [5:0]    af, ef;
        logic [DW-1:0] ad0, ad1, ed0, ed1;
        int            ep;
        ep = exp_phase(k);
        if (k == 0) begin
          ap = a_phase; ac = 8'(a_beat_cnt); ad0 = a_o0_data; ad1 = a_o1_data;
          af = {a_sel, a_busy, a_done, a_in_ready, a_o0_valid, a_o1_valid};
        end else begin
          ap = b_phase; ac = 8'(b_beat_cnt); ad0 = b_o0_data; ad1 = b_o1_data;
          af = {b_sel, b_busy, b_done, b_in_ready, b_o0_valid, b_o1_valid};
        end
        ef  = {m_sel[k], ep != 0, m_done[k], exp_ready(k), in_valid && ep == 1, in_valid && ep == 3};
        ed0 = m_sel[k] ? '0 : in_data;
        ed1 = m_sel[k] ? in_data : '0;
        checks++; if (ap !== 2'(ep)) begin errors++; $display("FAIL rnd_phase c%0d i%0d: got %0d exp %0d", n, k, ap, ep); end
        checks++; if (ac !== 8'(exp_cnt(k))) begin errors++; $display("FAIL rnd_cnt c%0d i%0d: got %0d exp %0d", n, k, ac, exp_cnt(k)); end
        checks++; if (af !== ef) begin errors++; $display("FAIL rnd_flags c%0d i%0d: got %b exp %b", n, k, af, ef); end
        checks++; if (ad0 !== ed0 || ad1 !== ed1) begin errors++; $display("FAIL rnd_data c%0d i%0d: got %h/%h exp %h/%h", n, k, ad0, ad1, ed0, ed1); end
`ifdef BN_DMUX_STALL_CNT_EN
        checks++;
        if ((k == 0 ? a_stall_cnt : b_stall_cnt) !== m_stall[k]) begin
          errors++; $display("FAIL rnd_stall c%0d i%0d: got %0d exp %0d", n, k, (k == 0 ? a_stall_cnt : b_stall_cnt), m_stall[k]);
        end
`endif
      end
      tick();
    end
  endtask

  initial begin
    bl[0] = BL_A;
    bl[1] = BL_B;
    rst = 1'b1; start = 1'b0; stat_done = 1'b0; in_valid = 1'b0;
    o0_ready = 1'b0; o1_ready = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_len1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
